// File: rtl/sort_stream_pkg.sv
// Shared types for the sorter stream controller: FSM state encoding and
// frame-size helper.
package sort_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_READ,
    ST_FLUSH
  } state_e;

  localparam int unsigned SKID_ENTRIES = 2;

  function automatic int unsigned frame_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/sort_stream_ctrl_skid.sv
// Two-entry FIFO holding sorter read data (plus last tag) in front of the
// output stream; the controller's read credit keeps it from overflowing.
module sort_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sort_stream_ctrl.sv
// Host-side initiator: loads a frame into the sorter, kicks it, waits for
// done, then streams the sorted frame out through a 2-entry skid buffer.
module sort_stream_ctrl
  import sort_stream_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         srt_wrinit,
  output logic [N-1:0] srt_datain,
  output logic         srt_rd,
  output logic [L-1:0] srt_raddr,
  output logic         srt_start,
  input  logic [N-1:0] srt_dataout,
  input  logic         srt_done,
  output state_e       dbg_state
);

  localparam int unsigned  DEPTH     = frame_depth(L);
  localparam logic [L-1:0] LAST_ADDR = L'(DEPTH - 1);

  state_e       state_q, state_d;
  logic [L-1:0] waddr_q, waddr_d;
  logic [L-1:0] raddr_q, raddr_d;
  logic         inflight_q, inflight_last_q;
  logic         wait_seen_q;
  logic         rst_seen_q;

  logic [1:0]   fifo_count;
  logic [N:0]   fifo_head;
  logic         fifo_pop;
  logic [2:0]   occupancy;

  // Handshake: a word moves on any edge where valid && ready; valid never
  // waits on ready, and data/last hold steady while valid && !ready.
  assign m_valid   = (fifo_count != 2'd0);
  assign fifo_pop  = m_valid & m_ready;
  assign m_data    = m_valid ? fifo_head[N-1:0] : '0;
  assign m_last    = m_valid & fifo_head[N];
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    s_ready    = 1'b0;
    srt_wrinit = 1'b0;
    srt_rd     = 1'b0;
    srt_start  = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        // Input is held off for the one cycle after reset so all outputs read 0.
        s_ready = ~rst_seen_q;
        if (s_valid && s_ready) begin
          srt_wrinit = 1'b1;
          waddr_d    = waddr_q + L'(1);
          if (state_q == ST_IDLE)        state_d = ST_LOAD;
          else if (waddr_q == LAST_ADDR) state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        srt_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // done is still stale on the first WAIT cycle, so it is not trusted yet.
        if (wait_seen_q && srt_done) begin
          state_d = ST_READ;
          raddr_d = '0;
        end
      end
      ST_READ: begin
        if (occupancy < 3'd2) begin
          srt_rd  = 1'b1;
          raddr_d = raddr_q + L'(1);
          if (raddr_q == LAST_ADDR) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_pop && fifo_head[N]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign srt_raddr  = srt_wrinit ? waddr_q : (srt_rd ? raddr_q : '0);
  assign srt_datain = srt_wrinit ? s_data : '0;

  always_ff @(posedge clk) begin
    rst_seen_q <= rst;
    if (rst) begin
      state_q         <= ST_IDLE;
      waddr_q         <= '0;
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wait_seen_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      waddr_q         <= waddr_d;
      raddr_q         <= raddr_d;
      inflight_q      <= srt_rd;
      inflight_last_q <= srt_rd && (raddr_q == LAST_ADDR);
      wait_seen_q     <= (state_q == ST_WAIT);
    end
  end

  sort_skid_buf #(.W(N + 1)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, srt_dataout}),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Directed bench for sort_stream_ctrl with a behavioural sorter model and an
// output scoreboard.
module tb_sort_stream_ctrl;
  import sort_stream_pkg::*;

  localparam int N = 8;
  localparam int L = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         s_valid = 1'b0, s_ready;
  logic [N-1:0] s_data = '0;
  logic         m_valid, m_ready = 1'b1, m_last;
  logic [N-1:0] m_data;
  logic         busy, srt_wrinit, srt_rd, srt_start;
  logic [N-1:0] srt_datain;
  logic [L-1:0] srt_raddr;
  logic [N-1:0] srt_dataout = '0;
  logic         srt_done = 1'b1;
  state_e       dbg_state;

  sort_stream_ctrl #(.N(N), .L(L)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy),
    .srt_wrinit(srt_wrinit), .srt_datain(srt_datain), .srt_rd(srt_rd),
    .srt_raddr(srt_raddr), .srt_start(srt_start),
    .srt_dataout(srt_dataout), .srt_done(srt_done),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- sorter model ----------------
  logic [N-1:0] smem [DEPTH];
  logic [N-1:0] tmp;
  int sphase = 0;
  int scnt = 0;

  always @(posedge clk) begin
    if (srt_wrinit) smem[srt_raddr] = srt_datain;
    if (srt_rd) srt_dataout <= smem[srt_raddr];
    case (sphase)
      0: if (srt_start) sphase = 1;
      1: begin srt_done <= 1'b0; scnt = 6; sphase = 2; end
      default: begin
        scnt--;
        if (scnt == 0) begin
          for (int a = 0; a < DEPTH - 1; a++)
            for (int b = 0; b < DEPTH - 1 - a; b++)
              if (smem[b] > smem[b+1]) begin
                tmp = smem[b]; smem[b] = smem[b+1]; smem[b+1] = tmp;
              end
          srt_done <= 1'b1;
          sphase = 0;
        end
      end
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] e;
  int wr_idx = 0, wr_cnt = 0, start_cnt = 0;
  int out_idx = 0, frames_out = 0;
  int issued = 0, accepted = 0;
  bit locked = 0, seen_rd = 0, seen_val = 0;
  int first_rd_cyc = 0, first_val_cyc = 0, first_acc_cyc = 0, last_acc_cyc = 0;
  bit hold_v = 0, hold_l = 0;
  logic [N-1:0] hold_d = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (locked) check_eq("s_ready_locked", s_ready, 0);
      if (s_valid && s_ready) begin
        check_eq("wr_en", srt_wrinit, 1);
        check_eq("wr_addr", srt_raddr, wr_idx);
        check_eq("wr_data", srt_datain, s_data);
        wr_idx = (wr_idx + 1) % DEPTH;
        wr_cnt++;
        if (wr_cnt == DEPTH) locked = 1;
      end else begin
        check_eq("wr_idle", srt_wrinit, 0);
      end
      if (srt_start) begin
        check_eq("start_after_load", wr_cnt, DEPTH);
        wr_cnt = 0;
        start_cnt++;
      end
      if (srt_rd) begin
        if (!seen_rd) begin
          check_eq("rd_after_done", srt_done, 1);
          first_rd_cyc = cyc;
          seen_rd = 1;
        end
        issued++;
      end
      if (m_valid && !seen_val) begin
        first_val_cyc = cyc;
        seen_val = 1;
      end
      if (hold_v) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_data", m_data, hold_d);
        check_eq("stall_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        accepted++;
        if (exp_q.size() == 0) check_eq("out_queue_empty", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("out_data", m_data, e);
        end
        check_eq("out_last", m_last, out_idx == DEPTH - 1);
        if (out_idx == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        out_idx = (out_idx + 1) % DEPTH;
        if (m_last) begin
          frames_out++;
          locked = 0;
        end
      end
      if (srt_rd) check_eq("read_credit", (issued - accepted) <= 2, 1);
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  // ---------------- output-ready driver ----------------
  int mode = 0;
  int stall_cnt = 0;
  bit stalled = 0;

  initial forever begin
    @(posedge clk); #1;
    if (mode == 0) m_ready = 1'b1;
    else if (stall_cnt > 0) begin m_ready = 1'b0; stall_cnt--; end
    else if (out_idx == 6 && !stalled) begin stalled = 1; stall_cnt = 4; m_ready = 1'b0; end
    else m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- input driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic send_word(input logic [N-1:0] v, input bit gap);
    int t;
    s_valid = 1'b1;
    s_data  = v;
    t = 0;
    while (!s_ready && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) check_eq("s_ready_timeout", t, 0);
    @(posedge clk); #1;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // kind 0: 15..0 ; kind 1: 0x20+(7i+3)%16 ; kind 2: 0x40+(5i+1)%16
  task automatic send_frame(input int kind, input bit gap);
    logic [N-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      if (kind == 0)      v = N'(15 - i);
      else if (kind == 1) v = N'(8'h20 + (i * 7 + 3) % 16);
      else                v = N'(8'h40 + (i * 5 + 1) % 16);
      send_word(v, gap);
    end
    s_valid = 1'b0;
  endtask

  task automatic push_exp(input int base);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(N'(base + i));
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_out < target && t < 3000) begin @(negedge clk); #1; t++; end
    check_eq("frame_done_in_time", frames_out >= target, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_last"}, m_last, 0);
    check_eq({tag, "_m_data"}, m_data, 0);
    check_eq({tag, "_s_ready"}, s_ready, 0);
    check_eq({tag, "_wrinit"}, srt_wrinit, 0);
    check_eq({tag, "_datain"}, srt_datain, 0);
    check_eq({tag, "_rd"}, srt_rd, 0);
    check_eq({tag, "_raddr"}, srt_raddr, 0);
    check_eq({tag, "_start"}, srt_start, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_ready", s_ready, 1);
    check_eq("idle_busy", busy, 0);

    // Frame 1: descending input, no gaps, no backpressure.
    push_exp(0);
    send_frame(0, 1'b0);
    wait_frames(1);
    check_eq("f1_latency", first_val_cyc - first_rd_cyc, 2);
    check_eq("f1_burst", last_acc_cyc - first_acc_cyc, 15);
    check_eq("f1_starts", start_cnt, 1);

    // Frame 2: gapped input.
    push_exp(8'h20);
    send_frame(1, 1'b1);
    wait_frames(2);
    check_eq("f2_starts", start_cnt, 2);

    // Frame 3: random backpressure with a long stall mid-frame.
    mode = 1;
    push_exp(8'h40);
    send_frame(2, 1'b0);
    wait_frames(3);
    mode = 0;
    check_eq("f3_starts", start_cnt, 3);
    check_eq("f3_stalled", stalled, 1);

    // Frame 4: reset after 7 output words.
    push_exp(0);
    send_frame(0, 1'b0);
    t = 0;
    while (out_idx < 7 && t < 3000) begin @(negedge clk); #1; t++; end
    check_eq("f4_reached_7", out_idx, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    exp_q.delete();
    out_idx = 0; wr_idx = 0; wr_cnt = 0;
    issued = 0; accepted = 0; locked = 0; hold_v = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("f4_starts", start_cnt, 4);

    // Frame 5: fresh frame after reset.
    push_exp(8'h20);
    send_frame(1, 1'b0);
    wait_frames(4);

    // Frames 6/7: back-to-back, second waits for IDLE.
    push_exp(8'h40);
    push_exp(0);
    send_frame(2, 1'b0);
    send_frame(0, 1'b0);
    wait_frames(6);
    check_eq("final_starts", start_cnt, 7);
    check_eq("final_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check_eq("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
